accum_buffer: RTL and testbench

Parametrised fixed-point accumulation buffer for the VAE datapath. It sums a group of DEPTH signed samples plus a per-group bias, then presents the result in an output register held under a valid/ready handshake. Each group's result is either saturated or wrapped to DATA_W bits. It sits between the fixed-point multiplier stream and the activation/next-layer stage, and replaces the fixed 16-bit, fixed-count buffer with back-pressure, bias, clear and overflow reporting.

---
 rtl/accum_buffer.sv | 94 +++++++++
 tb/tb_accum_buffer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/accum_buffer.sv
// rtl/accum_buffer.sv - signed group accumulator with bias, saturate/wrap and valid/ready result register
module accum_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 137,
    parameter int CNT_W  = 8,
    parameter int ACC_W  = 24,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] bias,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    input  logic              out_ready
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        cnt;
    logic                    is_first;
    logic                    is_last;
    logic                    beat;
    logic [DATA_W-1:0]       res_data;
    logic                    res_sat;

    assign in_ext   = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};

    // The final beat stalls only when it would overwrite an unread result.
    always_comb begin
        is_first = (cnt == '0);
        is_last  = (cnt == LAST_CNT);
        in_ready = !clear && (!is_last || !out_valid || out_ready);
        beat     = in_valid && in_ready;
        base     = is_first ? bias_ext : acc;
        sum      = base + in_ext;
    end

    always_comb begin
        res_data = sum[DATA_W-1:0];
        res_sat  = 1'b0;
        if (SAT != 0) begin
            if (sum > MAX_V) begin
                res_data = MAX_V[DATA_W-1:0];
                res_sat  = 1'b1;
            end else if (sum < MIN_V) begin
                res_data = MIN_V[DATA_W-1:0];
                res_sat  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (beat) begin
                if (is_last) begin
                    acc       <= '0;
                    cnt       <= '0;
                    out_data  <= res_data;
                    out_sat   <= res_sat;
                    out_valid <= 1'b1;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_accum_buffer.sv
// tb/tb_accum_buffer.sv - scoreboard bench for accum_buffer, saturating and wrapping instances
module tb_accum_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic [DW-1:0] d_sat;
        logic          s_sat;
        logic [DW-1:0] d_wrap;
    } result_t;

    logic          clk;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [DW-1:0] bias;
    logic          out_ready;

    logic          s_in_ready, s_out_valid, s_out_sat;
    logic [DW-1:0] s_out_data;
    logic          w_in_ready, w_out_valid, w_out_sat;
    logic [DW-1:0] w_out_data;

    int vectors;
    int miscompares;

    result_t       exp_q[$];
    logic [DW-1:0] grp[$];
    logic [DW-1:0] grp_bias;
    logic [DW-1:0] last_sat_d, last_wrap_d;
    logic          last_sat_s;

    accum_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(2), .ACC_W(19), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .bias(bias), .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_sat(s_out_sat), .out_ready(out_ready)
    );

    accum_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(2), .ACC_W(19), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .bias(bias), .in_ready(w_in_ready), .out_valid(w_out_valid), .out_data(w_out_data),
        .out_sat(w_out_sat), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the result registers against the scoreboard head.
    always @(negedge clk) begin
        check("sat_out_valid", 32'(s_out_valid), 32'(exp_q.size() != 0));
        check("wrap_out_valid", 32'(w_out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("sat_out_data", 32'(s_out_data), 32'(exp_q[0].d_sat));
            check("sat_out_sat", 32'(s_out_sat), 32'(exp_q[0].s_sat));
            check("wrap_out_data", 32'(w_out_data), 32'(exp_q[0].d_wrap));
            check("wrap_out_sat", 32'(w_out_sat), 32'd0);
            if (out_ready) begin
                last_sat_d  = exp_q[0].d_sat;
                last_sat_s  = exp_q[0].s_sat;
                last_wrap_d = exp_q[0].d_wrap;
                void'(exp_q.pop_front());
            end
        end else begin
            check("sat_held_data", 32'(s_out_data), 32'(last_sat_d));
            check("sat_held_sat", 32'(s_out_sat), 32'(last_sat_s));
            check("wrap_held_data", 32'(w_out_data), 32'(last_wrap_d));
        end
    end

    // Reference model: decides acceptance for the coming edge and pushes finished groups.
    always @(negedge clk) begin
        logic exp_rdy;
        int   s;
        result_t r;
        #1;
        if (rst) begin
            grp.delete();
            exp_q.delete();
            last_sat_d  = '0;
            last_sat_s  = 1'b0;
            last_wrap_d = '0;
        end else begin
            exp_rdy = !clear && (grp.size() != DEPTH - 1 || exp_q.size() == 0 || out_ready);
            check("sat_in_ready", 32'(s_in_ready), 32'(exp_rdy));
            check("wrap_in_ready", 32'(w_in_ready), 32'(exp_rdy));
            if (clear) begin
                grp.delete();
            end else if (in_valid && exp_rdy) begin
                if (grp.size() == 0) grp_bias = bias;
                grp.push_back(in_data);
                if (grp.size() == DEPTH) begin
                    s = int'($signed(grp_bias));
                    foreach (grp[i]) s += int'($signed(grp[i]));
                    r.d_wrap = s[DW-1:0];
                    if (s > 32767) begin
                        r.d_sat = 16'h7FFF; r.s_sat = 1'b1;
                    end else if (s < -32768) begin
                        r.d_sat = 16'h8000; r.s_sat = 1'b1;
                    end else begin
                        r.d_sat = s[DW-1:0]; r.s_sat = 1'b0;
                    end
                    exp_q.push_back(r);
                    grp.delete();
                end
            end
        end
    end

    task automatic step(input logic r, input logic c, input logic v,
                        input logic [DW-1:0] d, input logic [DW-1:0] b, input logic o);
        rst = r; clear = c; in_valid = v; in_data = d; bias = b; out_ready = o;
        @(posedge clk);
        #1;
    endtask

    task automatic grp4(input logic [DW-1:0] b, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [DW-1:0] d3, input logic o);
        step(0, 0, 1, d0, b, o);
        step(0, 0, 1, d1, 16'h1234, o);
        step(0, 0, 1, d2, 16'h5678, o);
        step(0, 0, 1, d3, 16'h9ABC, o);
    endtask

    initial begin
        logic [DW-1:0] d;
        vectors = 0;
        miscompares = 0;
        last_sat_d = '0; last_sat_s = 1'b0; last_wrap_d = '0;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; bias = '0; out_ready = 1'b1;
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        grp4(16'h0010, 16'd1, 16'd2, 16'd3, 16'd4, 1);
        step(0, 0, 0, 0, 0, 1);
        grp4(16'h7000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 1);
        grp4(16'h8000, 16'hC000, 16'hC000, 16'hC000, 16'hC000, 1);
        step(0, 0, 0, 0, 0, 1);

        grp4(16'h0100, 16'd10, 16'd20, 16'd30, 16'd40, 0);
        step(0, 0, 1, 16'd7, 16'h0200, 0);
        step(0, 0, 1, 16'd8, 16'h0, 0);
        step(0, 0, 1, 16'd9, 16'h0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 16'd11, 16'h0, 0);
        step(0, 0, 1, 16'd11, 16'h0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);

        step(0, 0, 1, 16'd100, 16'h0300, 1);
        step(0, 0, 1, 16'd200, 16'h0, 1);
        step(0, 1, 1, 16'd300, 16'h0, 1);
        grp4(16'h0000, 16'd5, 16'd5, 16'd5, 16'd5, 1);
        step(0, 0, 0, 0, 0, 1);

        grp4(16'h0040, 16'd1, 16'd1, 16'd1, 16'd1, 0);
        step(0, 0, 1, 16'd50, 16'h0001, 0);
        step(0, 0, 1, 16'd60, 16'h0, 0);
        step(1, 0, 1, 16'd70, 16'h0, 0);
        grp4(16'hFFF0, 16'd3, 16'd4, 16'hFFFE, 16'd1, 1);
        step(0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 800; i++) begin
            if ($urandom % 3 == 0) d = ($urandom % 2 != 0) ? 16'h7FFF : 16'h8000;
            else d = 16'($urandom);
            step(($urandom % 150) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
                 d, 16'($urandom), ($urandom % 3) != 0);
        end

        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
